time_display_driver: RTL

//   Reader side of the packed 27-bit time word {hr[4:0],min[5:0],sec[5:0],ms[9:0]}

---
 rtl/time_display_driver.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/time_display_driver.sv
// Snapshots the packed {hr,min,sec,ms} time word, converts it to BCD with a serial
// double-dabble FSM and scans it onto a common-anode 7-segment display (HUNDREDTHS_EN adds ms digits).
module time_display_driver #(
    parameter int REFRESH_CYCLES = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
`ifdef HUNDREDTHS_EN
    localparam int ND = 8
`else
    localparam int ND = 6
`endif
) (
    input  logic          kh_clk,
    input  logic          reset,
    input  logic [26:0]   disp_time,
    input  logic          blank_lz,
    output logic [6:0]    seg,
    output logic [ND-1:0] an,
    output logic          dp,
    output logic          bad_time
);

    localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_CYCLES - 1);
    localparam logic INV = SEG_ACTIVE_LOW ? 1'b0 : 1'b1;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          wrap;
    logic [3:0]    iter;
    logic [21:0]   sh_hr, sh_min, sh_sec;
    logic          bad_snap;
    logic [3:0]    hr10, hr1, min10, min1, sec10, sec1;
`ifdef HUNDREDTHS_EN
    logic [21:0]   sh_ms;
    logic [3:0]    ms100, ms10;
`endif
    logic [2:0]    idx;
    logic [3:0]    digit;
    logic          dp_on;
    logic          is_hr10;
    logic [6:0]    seg_lo;
    logic [ND-1:0] an_lo;

    // {bcd[11:0], bin[9:0]}: add-3 correction on each BCD nibble, then shift left.
    function automatic logic [21:0] dabble_step(input logic [21:0] v);
        logic [21:0] t;
        t = v;
        for (int unsigned n = 0; n < 3; n++) begin
            if (t[10 + 4*n +: 4] >= 4'd5)
                t[10 + 4*n +: 4] = t[10 + 4*n +: 4] + 4'd3;
        end
        return {t[20:0], 1'b0};
    endfunction

    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    assign wrap = (cnt == CNT_MAX);

    always_ff @(posedge kh_clk or posedge reset) begin
        if (reset) cnt <= '0;
        else       cnt <= wrap ? '0 : cnt + CW'(1);
    end

    always_ff @(posedge kh_clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            iter     <= '0;
            sh_hr    <= '0;
            sh_min   <= '0;
            sh_sec   <= '0;
            bad_snap <= 1'b0;
            hr10     <= '0;
            hr1      <= '0;
            min10    <= '0;
            min1     <= '0;
            sec10    <= '0;
            sec1     <= '0;
            bad_time <= 1'b0;
`ifdef HUNDREDTHS_EN
            sh_ms    <= '0;
            ms100    <= '0;
            ms10     <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (wrap) state <= LOAD;
                LOAD: begin
                    sh_hr    <= {12'd0, 5'd0, disp_time[26:22]};
                    sh_min   <= {12'd0, 4'd0, disp_time[21:16]};
                    sh_sec   <= {12'd0, 4'd0, disp_time[15:10]};
`ifdef HUNDREDTHS_EN
                    sh_ms    <= {12'd0, disp_time[9:0]};
`endif
                    bad_snap <= (disp_time[26:22] > 5'd23) || (disp_time[21:16] > 6'd59) ||
                                (disp_time[15:10] > 6'd59) || (disp_time[9:0] > 10'd999);
                    iter     <= '0;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    sh_hr  <= dabble_step(sh_hr);
                    sh_min <= dabble_step(sh_min);
                    sh_sec <= dabble_step(sh_sec);
`ifdef HUNDREDTHS_EN
                    sh_ms  <= dabble_step(sh_ms);
`endif
                    iter   <= iter + 4'd1;
                    if (iter == 4'd9) state <= DONE;
                end
                DONE: begin
                    // All digits and the error flag change together so a scan never mixes snapshots.
                    hr10     <= sh_hr[17:14];
                    hr1      <= sh_hr[13:10];
                    min10    <= sh_min[17:14];
                    min1     <= sh_min[13:10];
                    sec10    <= sh_sec[17:14];
                    sec1     <= sh_sec[13:10];
`ifdef HUNDREDTHS_EN
                    ms100    <= sh_ms[21:18];
                    ms10     <= sh_ms[17:14];
`endif
                    bad_time <= bad_snap;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        digit   = '0;
        dp_on   = 1'b0;
        is_hr10 = 1'b0;
        case (idx)
`ifdef HUNDREDTHS_EN
            3'd0: digit = ms10;
            3'd1: digit = ms100;
            3'd2: begin digit = sec1; dp_on = 1'b1; end
            3'd3: digit = sec10;
            3'd4: begin digit = min1; dp_on = 1'b1; end
            3'd5: digit = min10;
            3'd6: begin digit = hr1; dp_on = 1'b1; end
            3'd7: begin digit = hr10; is_hr10 = 1'b1; end
`else
            3'd0: digit = sec1;
            3'd1: digit = sec10;
            3'd2: begin digit = min1; dp_on = 1'b1; end
            3'd3: digit = min10;
            3'd4: begin digit = hr1; dp_on = 1'b1; end
            3'd5: begin digit = hr10; is_hr10 = 1'b1; end
`endif
            default: ;
        endcase
        seg_lo = digit_seg(digit);
        if (bad_time) begin
            seg_lo = SEG_DASH;
            dp_on  = 1'b0;
        end else if (is_hr10 && blank_lz && hr10 == 4'd0) begin
            seg_lo = SEG_BLANK;
        end
        an_lo = ~(ND'(1) << idx);
    end

    always_ff @(posedge kh_clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
            seg <= {7{~INV}};
            an  <= {ND{~INV}};
            dp  <= ~INV;
        end else begin
            idx <= (idx == 3'(ND - 1)) ? 3'd0 : idx + 3'd1;
            seg <= seg_lo ^ {7{INV}};
            an  <= an_lo ^ {ND{INV}};
            dp  <= ~dp_on ^ INV;
        end
    end

endmodule
